// File: rtl/cacheline_adaptor_if.sv
// Bundle of cache-side and memory-side signals for the cacheline adaptor.
// slave: seen from the adaptor. master: seen from the cache/memory environment.
interface cacheline_adaptor_if #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
);
   logic [31:0]        address_i;
   logic               read_i;
   logic               write_i;
   logic [s_line-1:0]  line_i;
   logic [s_line-1:0]  line_o;
   logic               resp_o;
   logic [31:0]        address_o;
   logic               read_o;
   logic               write_o;
   logic [s_burst-1:0] burst_i;
   logic [s_burst-1:0] burst_o;
   logic               resp_i;

   modport slave (
      input  address_i, read_i, write_i, line_i, burst_i, resp_i,
      output line_o, resp_o, address_o, read_o, write_o, burst_o
   );

   modport master (
      output address_i, read_i, write_i, line_i, burst_i, resp_i,
      input  line_o, resp_o, address_o, read_o, write_o, burst_o
   );
endinterface

// File: rtl/cacheline_adaptor.sv
// Serves one full cache-line read or write as a burst of narrow memory beats,
// then pulses a single-cycle completion strobe back to the cache.
//
// state | meaning
// IDLE  | waiting for read_i/write_i; read wins when both are high
// READ  | collecting beats from burst_i into line_o, one per resp_i
// WRITE | presenting write-buffer beats on burst_o, one per resp_i
// DONE  | resp_o high for one cycle, then back to IDLE
module cacheline_adaptor #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
) (
   input  logic clk,
   input  logic rst,
   cacheline_adaptor_if.slave bus
);
   localparam int s_offset = $clog2(s_line/8);
   localparam int n_beats  = s_line/s_burst;
   localparam int cnt_w    = (n_beats > 1) ? $clog2(n_beats) : 1;
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats-1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state, state_n;
   logic [cnt_w-1:0]  cnt;
   logic [s_line-1:0] wbuf;
   logic [s_line-1:0] line_q;
   logic [31:0]       addr_q;
   logic              unused_offset;

   assign unused_offset = ^bus.address_i[s_offset-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (bus.read_i)       state_n = READ;
                else if (bus.write_i) state_n = WRITE;
         READ:  if (bus.resp_i && cnt == last_beat) state_n = DONE;
         WRITE: if (bus.resp_i && cnt == last_beat) state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.read_o  = (state == READ);
      bus.write_o = (state == WRITE);
      bus.resp_o  = (state == DONE);
      bus.burst_o = '0;
      if (state == WRITE) bus.burst_o = wbuf[s_burst*cnt +: s_burst];
   end

   assign bus.line_o    = line_q;
   assign bus.address_o = addr_q;

   // Datapath: address/buffer capture on acceptance, beat steering during bursts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         wbuf   <= '0;
         line_q <= '0;
         addr_q <= '0;
      end else begin
         case (state)
            IDLE: if (bus.read_i || bus.write_i) begin
               addr_q <= {bus.address_i[31:s_offset], {s_offset{1'b0}}};
               cnt    <= '0;
               if (!bus.read_i) wbuf <= bus.line_i;
            end
            READ: if (bus.resp_i) begin
               line_q[s_burst*cnt +: s_burst] <= bus.burst_i;
               cnt <= (cnt == last_beat) ? '0 : cnt + 1'b1;
            end
            WRITE: if (bus.resp_i) begin
               cnt <= (cnt == last_beat) ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: stimulus pushes expected completions,
// a monitor pops and compares them whenever resp_o is seen.
module tb_cacheline_adaptor;
   localparam int S_LINE  = 256;
   localparam int S_BURST = 64;
   localparam int N_BEATS = S_LINE/S_BURST;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cacheline_adaptor_if #(.s_line(S_LINE), .s_burst(S_BURST)) bus();
   cacheline_adaptor #(.s_line(S_LINE), .s_burst(S_BURST)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [255:0] line;
   } exp_t;

   exp_t sb_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   logic [255:0] last_rd = '0;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] req);
      total_cnt++;
      if (got === req) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, got, req);
   endtask

   function automatic logic [255:0] rnd_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   // Completion monitor
   always @(negedge clk) begin
      if (!rst && bus.resp_o) begin
         exp_t e;
         chk("resp_no_req_o", {bus.read_o, bus.write_o}, 2'b00);
         if (sb_q.size() == 0) begin
            chk("unexpected_resp", 1'b1, 1'b0);
         end else begin
            e = sb_q.pop_front();
            chk("resp_address", bus.address_o, e.addr);
            if (e.is_rd) chk("resp_line", bus.line_o, e.line);
         end
      end
   end

   // One cache transaction plus the memory's side of the burst. Called at posedge+1.
   task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wline, input logic [255:0] rline,
                      input bit use_pat, input logic [31:0] pat,
                      output int lat, output int first);
      exp_t e;
      int k, kb, act, cyc;
      bit r, write_phase;
      bus.read_i = rd;
      bus.write_i = wr;
      bus.address_i = addr;
      if (wr) bus.line_i = wline;
      e.is_rd = rd;
      e.addr  = addr & ~32'h1F;
      e.line  = rline;
      sb_q.push_back(e);
      k = 0; act = 0; cyc = 0; first = -1;
      forever begin
         kb = k;
         write_phase = 1'b0;
         if (bus.read_o || bus.write_o) begin
            if (first < 0) first = cyc;
            write_phase = bus.write_o;
            r = use_pat ? pat[act] : ($urandom_range(0, 3) != 0);
            act++;
            bus.resp_i  = r;
            bus.burst_i = (r && k < N_BEATS) ? rline[64*k +: 64] : {$urandom, $urandom};
            if (r) k++;
         end else begin
            bus.resp_i = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (rd) chk("read_wins_write_o", bus.write_o, 1'b0);
         if (!rd && write_phase) begin
            chk("burst_o_beat", bus.burst_o, wline[64*(kb % N_BEATS) +: 64]);
            chk("line_o_retained", bus.line_o, last_rd);
         end
         if (bus.resp_o) break;
         if (cyc > 200) begin
            chk("txn_timeout", 1'b1, 1'b0);
            break;
         end
         @(posedge clk);
         #1;
      end
      lat = cyc;
      chk("beats_consumed", k, N_BEATS);
      @(posedge clk);
      #1;
      bus.resp_i = 1'b0;
      if (rd) begin
         bus.read_i = 1'b0;
         last_rd = rline;
      end else begin
         bus.write_i = 1'b0;
      end
   endtask

   initial begin
      int lat, first;
      logic [255:0] l1, wl, rl;
      logic [63:0] x1, x2;
      logic [31:0] a_prev, addr;
      bit rd;

      rst = 1'b1;
      bus.address_i = '0; bus.read_i = 0; bus.write_i = 0; bus.line_i = '0;
      bus.burst_i = '0; bus.resp_i = 0;
      #12;
      chk("rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
      chk("rst_line_o", bus.line_o, '0);
      chk("rst_address_o", bus.address_o, '0);
      chk("rst_burst_o", bus.burst_o, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Gapless read
      l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      txn(1, 0, 32'h1234_567F, '0, l1, 1, 32'hFFFF_FFFF, lat, first);
      chk("read_latency", lat, N_BEATS + 2);
      chk("read_address_o", bus.address_o, 32'h1234_5660);
      chk("read_line_o", bus.line_o, l1);

      // Write with gap pattern 1,0,1,0,0,1,1
      wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      txn(0, 1, 32'h0000_1000, wl, '0, 1, 32'b1100101, lat, first);
      chk("write_gap_latency", lat, 9);
      chk("line_o_after_write", bus.line_o, l1);

      // Simultaneous request: read first, held write accepted afterwards
      rl = rnd_line(); wl = rnd_line();
      txn(1, 1, 32'h0BAD_F00D, wl, rl, 0, 0, lat, first);
      chk("simul_write_still_held", bus.write_i, 1'b1);
      txn(0, 1, 32'h0BAD_F00D, wl, '0, 0, 0, lat, first);
      chk("simul_write_idle_gap", first, 1);

      // Back-to-back read then gapless write
      rl = rnd_line(); wl = rnd_line();
      txn(1, 0, 32'h8000_0020, '0, rl, 0, 0, lat, first);
      txn(0, 1, 32'h4000_0047, wl, '0, 1, 32'hF, lat, first);
      chk("b2b_idle_gap", first, 1);
      chk("b2b_write_latency", lat, N_BEATS + 2);

      // Spurious resp_i in IDLE
      a_prev = bus.address_o;
      bus.resp_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.burst_i = {$urandom, $urandom};
         @(negedge clk);
         chk("spurious_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
         chk("spurious_addr", bus.address_o, a_prev);
         chk("spurious_line", bus.line_o, last_rd);
         @(posedge clk); #1;
      end
      bus.resp_i = 1'b0;

      // Reset after two beats of a read
      bus.read_i = 1'b1;
      bus.address_i = 32'hCAFE_0040;
      @(posedge clk); #1;
      x1 = {$urandom, $urandom};
      bus.resp_i = 1'b1; bus.burst_i = x1;
      @(posedge clk); #1;
      x2 = {$urandom, $urandom};
      bus.burst_i = x2;
      @(posedge clk); #1;
      bus.resp_i = 1'b0;
      @(negedge clk);
      l1 = bus.line_o;
      chk("pre_reset_beats", l1[127:0], {x2, x1});
      chk("pre_reset_read_o", bus.read_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
      chk("mid_rst_line_o", bus.line_o, '0);
      chk("mid_rst_address_o", bus.address_o, '0);
      bus.read_i = 1'b0;
      last_rd = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      rl = rnd_line();
      txn(1, 0, 32'hCAFE_0040, '0, rl, 1, 32'hFFFF_FFFF, lat, first);
      chk("post_rst_latency", lat, N_BEATS + 2);
      chk("post_rst_line_o", bus.line_o, rl);

      // Randomized traffic
      for (int i = 0; i < 12; i++) begin
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            @(posedge clk); #1;
         end
         rd = ($urandom_range(0, 1) == 1);
         addr = $urandom;
         rl = rnd_line(); wl = rnd_line();
         txn(rd, !rd, addr, wl, rl, 0, 0, lat, first);
         chk("rand_address_o", bus.address_o, addr & ~32'h1F);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
